// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared opcodes, funct3 encodings and memory-stage FSM states
// Revision  : 1.0
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// mem_load_align : shifts a doubleword to its byte lane, sign/zero-extends
// Revision       : 1.0
// ============================================================================
module mem_load_align
  import riscv_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  lane,
  input  logic [2:0]  funct3,
  output logic [63:0] result
);

  logic [63:0] w_sh;

  assign w_sh = rdata >> {lane, 3'b000};

  always_comb begin
    result = w_sh;
    case (funct3)
      F3_LB:   result = {{56{w_sh[7]}},  w_sh[7:0]};
      F3_LBU:  result = {56'd0,          w_sh[7:0]};
      F3_LH:   result = {{48{w_sh[15]}}, w_sh[15:0]};
      F3_LHU:  result = {48'd0,          w_sh[15:0]};
      F3_LW:   result = {{32{w_sh[31]}}, w_sh[31:0]};
      F3_LWU:  result = {32'd0,          w_sh[31:0]};
      default: result = w_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// mem_access : RV64 memory-access stage with req/ack data port and timeout
// Revision   : 1.0
// ============================================================================
module mem_access
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_V,
  input  logic        MEM_FLUSH,
  input  logic [31:0] MEM_IR,
  input  logic [63:0] MEM_SR2,
  input  logic [63:0] MEM_NPC,
  input  logic [63:0] MEM_ALU_RESULT,
  input  logic [63:0] MEM_CSRFD,
  input  logic [63:0] MEM_RFD,
  input  logic        MEM_PC_MUX,
  input  logic [4:0]  MEM_DRID,
  input  logic        MEM_ECALL,
  output logic        MEM_STALL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [63:0] DMEM_ADDR,
  output logic [63:0] DMEM_WDATA,
  output logic [7:0]  DMEM_WSTRB,
  input  logic        DMEM_ACK,
  input  logic [63:0] DMEM_RDATA,
  input  logic        DMEM_ERR,
  output logic        WB_V,
  output logic [63:0] WB_MEM_RESULT,
  output logic [63:0] WB_NPC,
  output logic [63:0] WB_ALU_RESULT,
  output logic [63:0] WB_CSRFD,
  output logic [63:0] WB_RFD,
  output logic [31:0] WB_IR,
  output logic        WB_PC_MUX,
  output logic [4:0]  WB_DRID,
  output logic        WB_ECALL,
  output logic        MEM_LAM,
  output logic        MEM_LAF,
  output logic        MEM_SAM,
  output logic        MEM_SAF
);

  mem_state_t  r_state;
  logic [7:0]  r_cnt;

  logic [2:0]  w_funct3;
  logic [2:0]  w_lane;
  logic [2:0]  w_align_mask;
  logic [7:0]  w_size_mask;
  logic        w_is_load, w_is_store, w_is_mem;
  logic        w_bad_f3, w_misal, w_memop, w_timeout;
  logic        w_idle, w_wait, w_drain;
  logic        w_go_wait, w_wait_end, w_mem_done, w_bus_fault, w_acc_fault, w_wb_v;
  logic [63:0] w_load_data;

  assign w_funct3   = MEM_IR[14:12];
  assign w_lane     = MEM_ALU_RESULT[2:0];
  assign w_is_load  = (MEM_IR[6:0] == OP_LOAD);
  assign w_is_store = (MEM_IR[6:0] == OP_STORE);
  assign w_is_mem   = w_is_load || w_is_store;

  always_comb begin
    w_align_mask = 3'b111;
    w_size_mask  = 8'hFF;
    case (w_funct3[1:0])
      2'b00:   begin w_align_mask = 3'b000; w_size_mask = 8'h01; end
      2'b01:   begin w_align_mask = 3'b001; w_size_mask = 8'h03; end
      2'b10:   begin w_align_mask = 3'b011; w_size_mask = 8'h0F; end
      default: begin w_align_mask = 3'b111; w_size_mask = 8'hFF; end
    endcase
  end

  assign w_bad_f3 = (w_is_load && (w_funct3 == 3'b111)) || (w_is_store && w_funct3[2]);
  assign w_misal  = w_is_mem && !w_bad_f3 && (|(w_lane & w_align_mask));
  assign w_memop  = MEM_V && !MEM_FLUSH && w_is_mem && !w_bad_f3 && !w_misal;

  assign w_idle    = (r_state == IDLE);
  assign w_wait    = (r_state == WAIT);
  assign w_drain   = (r_state == DRAIN);
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  assign w_go_wait   = w_idle && w_memop && !DMEM_ACK;
  assign w_wait_end  = DMEM_ACK || w_timeout;
  assign w_mem_done  = (w_idle && w_memop && DMEM_ACK) || (w_wait && w_wait_end);
  // Without an ack the only way to finish is the timeout, which is a fault.
  assign w_bus_fault = DMEM_ACK ? DMEM_ERR : 1'b1;
  assign w_acc_fault = w_bad_f3 || (w_mem_done && w_bus_fault);
  assign w_wb_v      = (w_idle && MEM_V && !MEM_FLUSH && !w_go_wait) ||
                       (w_wait && !MEM_FLUSH && w_wait_end);

  assign MEM_STALL  = RESET && (w_go_wait || (w_wait && !w_wait_end) || w_drain);
  assign DMEM_REQ   = RESET && ((w_idle && w_memop) || w_wait || w_drain);
  assign DMEM_WE    = DMEM_REQ && w_is_store;
  assign DMEM_WSTRB = DMEM_WE ? (w_size_mask << w_lane) : 8'h00;
  assign DMEM_ADDR  = {MEM_ALU_RESULT[63:3], 3'b000};
  assign DMEM_WDATA = MEM_SR2 << {w_lane, 3'b000};

  mem_load_align u_align (
    .rdata  (DMEM_RDATA),
    .lane   (w_lane),
    .funct3 (w_funct3),
    .result (w_load_data)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go_wait) begin
            r_state <= WAIT;
            r_cnt   <= 8'd1;
          end
        end
        WAIT: begin
          if (w_wait_end) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_state <= MEM_FLUSH ? DRAIN : WAIT;
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (w_wait_end) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WB_V          <= 1'b0;
      WB_MEM_RESULT <= 64'd0;
      WB_NPC        <= 64'd0;
      WB_ALU_RESULT <= 64'd0;
      WB_CSRFD      <= 64'd0;
      WB_RFD        <= 64'd0;
      WB_IR         <= 32'd0;
      WB_PC_MUX     <= 1'b0;
      WB_DRID       <= 5'd0;
      WB_ECALL      <= 1'b0;
      MEM_LAM       <= 1'b0;
      MEM_LAF       <= 1'b0;
      MEM_SAM       <= 1'b0;
      MEM_SAF       <= 1'b0;
    end else begin
      WB_V          <= w_wb_v;
      WB_MEM_RESULT <= (w_wb_v && w_is_load && w_mem_done && !w_bus_fault) ? w_load_data : 64'd0;
      WB_NPC        <= MEM_NPC;
      WB_ALU_RESULT <= MEM_ALU_RESULT;
      WB_CSRFD      <= MEM_CSRFD;
      WB_RFD        <= MEM_RFD;
      WB_IR         <= MEM_IR;
      WB_PC_MUX     <= MEM_PC_MUX;
      WB_DRID       <= MEM_DRID;
      WB_ECALL      <= MEM_ECALL;
      MEM_LAM       <= w_wb_v && w_is_load  && w_misal;
      MEM_LAF       <= w_wb_v && w_is_load  && w_acc_fault;
      MEM_SAM       <= w_wb_v && w_is_store && w_misal;
      MEM_SAF       <= w_wb_v && w_is_store && w_acc_fault;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// tb_mem_access : directed stimulus with scoreboard checking of WB outputs
// Revision      : 1.0
// ============================================================================
module tb_mem_access;

  logic        CLK, RESET;
  logic        MEM_V, MEM_FLUSH;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_SR2, MEM_NPC, MEM_ALU_RESULT, MEM_CSRFD, MEM_RFD;
  logic        MEM_PC_MUX, MEM_ECALL;
  logic [4:0]  MEM_DRID;
  logic        MEM_STALL, DMEM_REQ, DMEM_WE;
  logic [63:0] DMEM_ADDR, DMEM_WDATA;
  logic [7:0]  DMEM_WSTRB;
  logic        DMEM_ACK, DMEM_ERR;
  logic [63:0] DMEM_RDATA;
  logic        WB_V;
  logic [63:0] WB_MEM_RESULT, WB_NPC, WB_ALU_RESULT, WB_CSRFD, WB_RFD;
  logic [31:0] WB_IR;
  logic        WB_PC_MUX, WB_ECALL;
  logic [4:0]  WB_DRID;
  logic        MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;

  mem_access #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_FLUSH(MEM_FLUSH), .MEM_IR(MEM_IR),
    .MEM_SR2(MEM_SR2), .MEM_NPC(MEM_NPC), .MEM_ALU_RESULT(MEM_ALU_RESULT),
    .MEM_CSRFD(MEM_CSRFD), .MEM_RFD(MEM_RFD), .MEM_PC_MUX(MEM_PC_MUX),
    .MEM_DRID(MEM_DRID), .MEM_ECALL(MEM_ECALL), .MEM_STALL(MEM_STALL),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB), .DMEM_ACK(DMEM_ACK),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_ERR(DMEM_ERR), .WB_V(WB_V),
    .WB_MEM_RESULT(WB_MEM_RESULT), .WB_NPC(WB_NPC), .WB_ALU_RESULT(WB_ALU_RESULT),
    .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD), .WB_IR(WB_IR), .WB_PC_MUX(WB_PC_MUX),
    .WB_DRID(WB_DRID), .WB_ECALL(WB_ECALL), .MEM_LAM(MEM_LAM), .MEM_LAF(MEM_LAF),
    .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF)
  );

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_AL = 7'b0110011;

  typedef struct {
    logic [63:0] res;
    logic [63:0] alu;
    logic [3:0]  flags;   // {LAM, LAF, SAM, SAF}
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          reqs;
  logic        cap_req, cap_we;
  logic [63:0] cap_addr, cap_wdata;
  logic [7:0]  cap_wstrb;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every valid writeback must match the oldest expected entry.
  always @(negedge CLK) begin
    if (RESET && WB_V) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb_v", 64'(WB_V), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_mem_result", WB_MEM_RESULT, e.res);
        chk("wb_alu_result", WB_ALU_RESULT, e.alu);
        chk("wb_npc",        WB_NPC,        e.alu + 64'd4);
        chk("fault_flags",   64'({MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF}), 64'(e.flags));
      end
    end
  end

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'd1, op};
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] sr2);
    MEM_V = 1'b1; MEM_IR = mk_ir(op, f3); MEM_ALU_RESULT = addr;
    MEM_SR2 = sr2; MEM_NPC = addr + 64'd4;
  endtask

  // dly = request cycle on which ACK is given (0 = same cycle), -1 = never.
  task automatic issue(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] sr2,
                       input logic [63:0] rdat, input int dly, input logic err,
                       input logic [63:0] eres, input logic [3:0] eflags, input int estall);
    exp_t e;
    int   k, stalls;
    bit   done;
    e.res = eres; e.alu = addr; e.flags = eflags;
    sb.push_back(e);
    @(posedge CLK); #1;
    set_instr(op, f3, addr, sr2);
    k = 0; stalls = 0; reqs = 0; done = 0;
    while (!done && k < 40) begin
      DMEM_ACK = (k == dly); DMEM_ERR = err && (k == dly); DMEM_RDATA = rdat;
      #1;
      if (k == 0) begin
        cap_req = DMEM_REQ; cap_we = DMEM_WE; cap_addr = DMEM_ADDR;
        cap_wdata = DMEM_WDATA; cap_wstrb = DMEM_WSTRB;
      end
      if (DMEM_REQ) reqs++;
      if (!MEM_STALL) done = 1;
      else begin
        stalls++; k++;
        @(posedge CLK); #1;
      end
    end
    if (!done) chk({name, "_stall_bound"}, 64'(k), 64'd0);
    chk({name, "_stall_cycles"}, 64'(stalls), 64'(estall));
    @(posedge CLK); #1;
    MEM_V = 1'b0; DMEM_ACK = 1'b0; DMEM_ERR = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; MEM_V = 1'b0; MEM_FLUSH = 1'b0; MEM_IR = '0; MEM_SR2 = '0;
    MEM_NPC = '0; MEM_ALU_RESULT = '0; MEM_CSRFD = 64'hC5; MEM_RFD = 64'hF0;
    MEM_PC_MUX = 1'b0; MEM_DRID = 5'd3; MEM_ECALL = 1'b0;
    DMEM_ACK = 1'b0; DMEM_ERR = 1'b0; DMEM_RDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wb_v",      64'(WB_V), 64'd0);
    chk("rst_wb_result", WB_MEM_RESULT, 64'd0);
    chk("rst_wb_alu",    WB_ALU_RESULT, 64'd0);
    chk("rst_flags",     64'({MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF}), 64'd0);
    chk("rst_req",       64'({DMEM_REQ, DMEM_WE, MEM_STALL}), 64'd0);
    chk("rst_wstrb",     64'(DMEM_WSTRB), 64'd0);
    RESET = 1'b1;

    issue("ld0", OP_LD, 3'b011, 64'h1000, 64'h0, 64'h1122334455667788, 0, 1'b0,
          64'h1122334455667788, 4'b0000, 0);
    chk("ld0_addr",  cap_addr, 64'h1000);
    chk("ld0_we",    64'({cap_req, cap_we}), 64'b10);
    chk("ld0_wstrb", 64'(cap_wstrb), 64'h00);

    issue("lb3", OP_LD, 3'b000, 64'h1003, 64'h0, 64'h0000000080000000, 3, 1'b0,
          64'hFFFFFFFFFFFFFF80, 4'b0000, 3);
    issue("lbu3", OP_LD, 3'b100, 64'h1003, 64'h0, 64'h0000000080000000, 3, 1'b0,
          64'h0000000000000080, 4'b0000, 3);
    issue("lh6", OP_LD, 3'b001, 64'h1006, 64'h0, 64'hBEEF000000000000, 2, 1'b0,
          64'hFFFFFFFFFFFFBEEF, 4'b0000, 2);
    issue("lhu6", OP_LD, 3'b101, 64'h1006, 64'h0, 64'hBEEF000000000000, 1, 1'b0,
          64'h000000000000BEEF, 4'b0000, 1);
    issue("lw4", OP_LD, 3'b010, 64'h1004, 64'h0, 64'h8000000112345678, 0, 1'b0,
          64'hFFFFFFFF80000001, 4'b0000, 0);
    issue("lwu4", OP_LD, 3'b110, 64'h1004, 64'h0, 64'h8000000112345678, 0, 1'b0,
          64'h0000000080000001, 4'b0000, 0);

    issue("sh6", OP_ST, 3'b001, 64'h2006, 64'hABCD, 64'h0, 0, 1'b0,
          64'h0, 4'b0000, 0);
    chk("sh6_wstrb", 64'(cap_wstrb), 64'hC0);
    chk("sh6_wdata", cap_wdata, 64'hABCD000000000000);
    chk("sh6_addr",  cap_addr, 64'h2000);
    chk("sh6_we",    64'(cap_we), 64'd1);

    issue("lw_mis", OP_LD, 3'b010, 64'h3002, 64'h0, 64'h0, -1, 1'b0,
          64'h0, 4'b1000, 0);
    chk("lw_mis_req", 64'(cap_req), 64'd0);
    issue("sw_mis", OP_ST, 3'b010, 64'h3006, 64'h55, 64'h0, -1, 1'b0,
          64'h0, 4'b0010, 0);
    issue("ld_f3bad", OP_LD, 3'b111, 64'h3000, 64'h0, 64'h0, -1, 1'b0,
          64'h0, 4'b0100, 0);
    chk("ld_f3bad_req", 64'(cap_req), 64'd0);

    issue("sd_tmo", OP_ST, 3'b011, 64'h4000, 64'h1234, 64'h0, -1, 1'b0,
          64'h0, 4'b0001, 3);
    chk("sd_tmo_req_cycles", 64'(reqs), 64'd4);

    issue("lw_err", OP_LD, 3'b010, 64'h5004, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1, 1'b1,
          64'h0, 4'b0100, 1);
    issue("sw_err", OP_ST, 3'b010, 64'h5000, 64'h77, 64'h0, 0, 1'b1,
          64'h0, 4'b0001, 0);
    issue("alu", OP_AL, 3'b000, 64'h6000, 64'h0, 64'h0, -1, 1'b0,
          64'h0, 4'b0000, 0);
    chk("alu_req", 64'(cap_req), 64'd0);

    // Flush while waiting: request drains, nothing reaches writeback.
    @(posedge CLK); #1;
    set_instr(OP_LD, 3'b011, 64'h7000, 64'h0);
    @(posedge CLK); #1;
    MEM_FLUSH = 1'b1;
    #1;
    chk("flush_wait_stall", 64'({DMEM_REQ, MEM_STALL}), 64'b11);
    @(posedge CLK); #1;
    MEM_FLUSH = 1'b0;
    #1;
    chk("drain_req_stall", 64'({DMEM_REQ, MEM_STALL}), 64'b11);
    chk("drain_wb_v", 64'(WB_V), 64'd0);
    @(posedge CLK); #1;
    MEM_V = 1'b0; DMEM_ACK = 1'b1; DMEM_RDATA = 64'hDEAD;
    @(posedge CLK); #1;
    DMEM_ACK = 1'b0;
    #1;
    chk("drain_to_idle", 64'({DMEM_REQ, MEM_STALL}), 64'b00);
    chk("drain_done_wb_v", 64'(WB_V), 64'd0);

    // Flush and ack in the same WAIT cycle: the flush wins.
    @(posedge CLK); #1;
    set_instr(OP_LD, 3'b011, 64'h7100, 64'h0);
    @(posedge CLK); #1;
    MEM_FLUSH = 1'b1; DMEM_ACK = 1'b1; DMEM_RDATA = 64'h99;
    @(posedge CLK); #1;
    MEM_V = 1'b0; MEM_FLUSH = 1'b0; DMEM_ACK = 1'b0;
    #1;
    chk("flush_ack_wb_v", 64'(WB_V), 64'd0);
    chk("flush_ack_idle", 64'({DMEM_REQ, MEM_STALL}), 64'b00);

    // Flush in IDLE: no request at all.
    @(posedge CLK); #1;
    set_instr(OP_LD, 3'b011, 64'h7200, 64'h0);
    MEM_FLUSH = 1'b1;
    #1;
    chk("flush_idle_req", 64'({DMEM_REQ, MEM_STALL}), 64'b00);
    @(posedge CLK); #1;
    MEM_V = 1'b0; MEM_FLUSH = 1'b0;
    chk("flush_idle_wb_v", 64'(WB_V), 64'd0);

    // Reset while waiting drops the request immediately.
    @(posedge CLK); #1;
    set_instr(OP_LD, 3'b011, 64'h7300, 64'h0);
    @(posedge CLK); #1;
    chk("pre_rst_req", 64'(DMEM_REQ), 64'd1);
    RESET = 1'b0;
    #1;
    chk("mid_rst_req", 64'({DMEM_REQ, MEM_STALL}), 64'b00);
    @(posedge CLK); #1;
    MEM_V = 1'b0;
    RESET = 1'b1;

    repeat (3) @(posedge CLK);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
